// File: rtl/mem_lsu_pkg.sv
// Shared constants for the memory-access stage: access sizes, FSM states, alignment helper.
package mem_lsu_pkg;

    localparam logic [1:0] LsuB = 2'b00;
    localparam logic [1:0] LsuH = 2'b01;
    localparam logic [1:0] LsuW = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StRsp  = 2'b10,
        StDone = 2'b11
    } lsu_state_e;

    // Size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
        logic mis;
        case (size)
            LsuB:    mis = 1'b0;
            LsuH:    mis = off[0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables, store replication, misalign flag, load extract/extend.
module mem_lsu_align (
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);
    import mem_lsu_pkg::*;

    logic [31:0] rdata_sh;

    // Store side: lane enables and data replicated across every lane it may land in.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        misalign  = is_misaligned(size, addr_lo);
        case (size)
            LsuB: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            LsuH: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Load side: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        rdata_sh = rdata >> {ld_off, 3'b000};
        case (ld_size)
            LsuB:    ld_data = {{24{~ld_unsigned & rdata_sh[7]}}, rdata_sh[7:0]};
            LsuH:    ld_data = {{16{~ld_unsigned & rdata_sh[15]}}, rdata_sh[15:0]};
            default: ld_data = rdata_sh;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: one load/store per instruction over a req/gnt/rvalid bus, with timeout.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic        misalign,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    import mem_lsu_pkg::*;

    localparam int unsigned TimerW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);

    lsu_state_e        state_q;
    logic [TimerW-1:0] timer_q;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [31:0]       bus_addr_q;
    logic [31:0]       bus_wdata_q;
    logic [3:0]        bus_be_q;
    logic [31:0]       rd_data_q;
    logic              err_q;

    logic [3:0]        be_w;
    logic [31:0]       wrep_w;
    logic [31:0]       ld_w;
    logic              mis_w;
    logic              accept;

    mem_lsu_align u_align (
        .size        (mem_size),
        .addr_lo     (addr[1:0]),
        .wdata       (wdata),
        .be          (be_w),
        .wdata_rep   (wrep_w),
        .misalign    (mis_w),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .ld_off      (off_q),
        .rdata       (bus_rdata),
        .ld_data     (ld_w)
    );

    // Launch decision and pipeline hold; a misaligned access never stalls or touches the bus.
    always_comb begin
        accept   = (state_q == StIdle) && mem_en && !mis_w;
        misalign = (state_q == StIdle) && mem_en && mis_w;
        stall    = accept || (state_q == StReq) || (state_q == StRsp);
    end

    assign done      = (state_q == StDone);
    assign bus_req   = (state_q == StReq);
    assign bus_we    = we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign rd_data   = rd_data_q;
    assign err       = err_q;

    // FSM, timeout timer and capture registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            rd_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        we_q        <= mem_we;
                        uns_q       <= mem_unsigned;
                        size_q      <= mem_size;
                        off_q       <= addr[1:0];
                        bus_addr_q  <= {addr[31:2], 2'b00};
                        bus_be_q    <= be_w;
                        bus_wdata_q <= wrep_w;
                        timer_q     <= '0;
                        err_q       <= 1'b0;
                        rd_data_q   <= '0;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    if (bus_gnt) begin
                        state_q <= we_q ? StDone : StRsp;
                        // Saturate so a late grant cannot buy a fresh timeout window in RSP.
                        if (timer_q != TimerLast) timer_q <= timer_q + 1'b1;
                    end else if (timer_q == TimerLast) begin
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StRsp: begin
                    if (bus_rvalid) begin
                        rd_data_q <= ld_w;
                        state_q   <= StDone;
                    end else if (timer_q == TimerLast) begin
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a small req/gnt/rvalid bus responder.
module tb_mem_lsu;

    logic        clk;
    logic        rstn;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic        misalign;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    mem_lsu #(.TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .rd_data      (rd_data),
        .done         (done),
        .err          (err),
        .misalign     (misalign),
        .stall        (stall),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_gnt      (bus_gnt),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Results captured by run_access.
    int          lat;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_stall_req;
    logic [31:0] r_rd;
    logic        r_err;
    logic        r_stall_done;
    logic        r_req_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one access and play the bus: grant after gnt_wait REQ cycles, rvalid the cycle
    // after grant. Returns with the DONE cycle current and mem_en already dropped.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat, input int gnt_wait);
        int   rq      = 0;
        logic granted = 1'b0;
        logic seen    = 1'b0;
        mem_en = 1'b1; mem_we = we; mem_size = sz; mem_unsigned = uns; addr = a; wdata = wd;
        tick();
        lat = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            lat++;
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            if (done) begin
                seen = 1'b1;
                r_rd = rd_data; r_err = err; r_stall_done = stall; r_req_done = bus_req;
                mem_en = 1'b0;
            end else begin
                if (lat == 1) begin
                    r_addr = bus_addr; r_wdata = bus_wdata; r_be = bus_be;
                    r_stall_req = stall & bus_req;
                end
                if (granted && !we) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rdat;
                end
                if (bus_req && rq >= gnt_wait) begin
                    bus_gnt = 1'b1;
                    granted = 1'b1;
                end
                if (bus_req) rq++;
                tick();
            end
        end
        check("done_seen", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        rstn = 1'b0; mem_en = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
        addr = '0; wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        #12;
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_req", {31'b0, bus_req}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", {28'b0, bus_be}, 32'd0);
        rstn = 1'b1;
        tick();

        // SW, zero-wait grant
        run_access(1'b1, 2'b10, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0);
        check("sw_lat", lat, 32'd2);
        check("sw_addr", r_addr, 32'h0000_1004);
        check("sw_be", {28'b0, r_be}, 32'hF);
        check("sw_wdata", r_wdata, 32'hDEAD_BEEF);
        check("sw_stall_req", {31'b0, r_stall_req}, 32'd1);
        check("sw_stall_done", {31'b0, r_stall_done}, 32'd0);
        check("sw_err", {31'b0, r_err}, 32'd0);
        tick();
        check("sw_no_relaunch_done", {31'b0, done}, 32'd0);
        check("sw_no_relaunch_req", {31'b0, bus_req}, 32'd0);

        // LB / LBU from the top byte lane
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0, 32'h8011_2233, 0);
        check("lb_lat", lat, 32'd3);
        check("lb_be", {28'b0, r_be}, 32'h8);
        check("lb_addr", r_addr, 32'h0000_2000);
        check("lb_rd", r_rd, 32'hFFFF_FF80);
        tick();
        run_access(1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 32'h8011_2233, 0);
        check("lbu_rd", r_rd, 32'h0000_0080);
        tick();

        // SH / LH on the upper half
        run_access(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 32'h0, 0);
        check("sh_be", {28'b0, r_be}, 32'hC);
        check("sh_wdata", r_wdata, 32'hABCD_ABCD);
        tick();
        run_access(1'b0, 2'b01, 1'b0, 32'h0000_3002, 32'h0, 32'h7FFF_0000, 0);
        check("lh_rd", r_rd, 32'h0000_7FFF);
        tick();

        // Misalignment: LW and LH at 0x4001 flagged, LB not
        mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0; addr = 32'h0000_4001;
        #1;
        check("lw_mis", {31'b0, misalign}, 32'd1);
        check("lw_mis_stall", {31'b0, stall}, 32'd0);
        tick();
        check("lw_mis_no_req", {31'b0, bus_req}, 32'd0);
        tick();
        check("lw_mis_no_req2", {31'b0, bus_req}, 32'd0);
        mem_size = 2'b01;
        #1;
        check("lh_mis", {31'b0, misalign}, 32'd1);
        mem_size = 2'b00;
        #1;
        check("lb_not_mis", {31'b0, misalign}, 32'd0);
        check("lb_not_mis_stall", {31'b0, stall}, 32'd1);
        mem_en = 1'b0;
        tick();

        // LW with grant withheld: timeout after 16 REQ cycles
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 32'h1234_5678, 100);
        check("to_lat", lat, 32'd17);
        check("to_err", {31'b0, r_err}, 32'd1);
        check("to_rd", r_rd, 32'd0);
        check("to_req", {31'b0, r_req_done}, 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        bus_rvalid = 1'b0;
        check("late_rv_rd", rd_data, 32'd0);
        check("late_rv_err", {31'b0, err}, 32'd1);
        check("late_rv_done", {31'b0, done}, 32'd0);

        // Reset while waiting in RSP
        mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0; addr = 32'h0000_6000;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check("rsp_stall", {31'b0, stall}, 32'd1);
        #2;
        mem_en = 1'b0;
        rstn = 1'b0;
        #1;
        check("mid_rst_req", {31'b0, bus_req}, 32'd0);
        check("mid_rst_stall", {31'b0, stall}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_addr", bus_addr, 32'd0);
        check("mid_rst_err", {31'b0, err}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        run_access(1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'h1234_5678, 32'h0, 0);
        check("post_rst_lat", lat, 32'd2);
        check("post_rst_addr", r_addr, 32'h0000_7000);
        check("post_rst_wdata", r_wdata, 32'h1234_5678);
        check("post_rst_err", {31'b0, r_err}, 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage of the nano_riscv pipeline.
- Consumes the execute-stage ALU result as the effective address and rs2 as store data.
- Runs one load or store per instruction over a req/gnt/rvalid data-bus handshake, and stalls the pipeline until the access completes.
- Returns sign/zero-extended load data to writeback, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYC, 16, max cycles spent in REQ+RSP before the access is aborted with err (min 2).

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- mem_en  in  1  current instruction is a load/store; held stable while stall=1
- mem_we  in  1  1=store, 0=load
- mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_unsigned  in  1  zero-extend load (LBU/LHU)
- addr  in  32  effective address from execute result
- wdata  in  32  store data (rs2)
- rd_data  out  32  extended load data; valid while done=1
- done  out  1  one-cycle completion pulse
- err  out  1  bus timeout; valid with done
- misalign  out  1  misaligned access detected; no bus access made
- stall  out  1  hold IF/ID/EX
- bus_req  out  1  request valid
- bus_we  out  1  write request
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data word

Behaviour:
- FSM states: IDLE, REQ, RSP, DONE.
- Reset (async, rstn=0): state=IDLE; all outputs 0, including rd_data, bus_* and the timer. Mid-transaction reset drops bus_req immediately.
- Alignment rule: half needs addr[0]=0; word needs addr[1:0]=00.
- IDLE, mem_en=1 and misaligned:
  - misalign=1 combinationally, stall=0, no state change, no bus activity.
  - Trap handling is elsewhere.
- IDLE, mem_en=1 and aligned:
  - stall=1 combinationally.
  - At the edge: register we, size, unsigned, addr[1:0], bus_addr, bus_be, bus_wdata; clear timer; go to REQ.
- REQ:
  - bus_req=1, stall=1; bus outputs stable until gnt.
  - On bus_gnt: store goes to DONE; load goes to RSP.
- RSP:
  - bus_req=0, stall=1.
  - On bus_rvalid: capture extended data into rd_data, go to DONE.
  - rvalid is only honoured in RSP, never in the gnt cycle.
- DONE:
  - done=1, stall=0, go to IDLE.
  - The pipeline advances on this edge, so the same instruction is never relaunched.
- Timer:
  - Increments each cycle in REQ/RSP.
  - When it reaches TIMEOUT_CYC-1 without gnt (REQ) or rvalid (RSP): go to DONE with err=1, rd_data=0, bus_req dropped.
  - A stale rvalid arriving later in IDLE/DONE is ignored.
- err and rd_data hold until the next access starts.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<{addr[1],1'b0}
  - word: 1111
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extract: bus_rdata >> (8*addr[1:0]). Take byte/half/word, then sign-extend bit 7/15 unless mem_unsigned.
- Latency, zero-wait bus:
  - store: accept→REQ (gnt)→DONE, done 2 cycles after acceptance.
  - load with rvalid the cycle after gnt: done 3 cycles after acceptance.
- mem_en=0 in IDLE: stall=0, nothing happens.

Decomposition:
- defines.v holds the shared constants: size encodings (LSU_B/LSU_H/LSU_W), FSM state encodings, and the existing InstBus/Wordnum/ZeroWord.
- State, timer and capture registers use the existing DFF primitive.
- One combinational sub-module, lsu_align: computes bus_be, replicated wdata, misalign flag and load extract/extend from size/unsigned/addr[1:0]/rdata.

Test Plan:
- SW addr=0x1004 wdata=0xDEADBEEF, gnt immediate → bus_addr=0x1004, be=1111, wdata=0xDEADBEEF, done 2 cycles after accept, stall low on done cycle.
- LB addr=0x2003, bus_rdata=0x80112233, rvalid cycle after gnt → rd_data=0xFFFFFF80. LBU same → 0x00000080. be=1000.
- SH addr=0x3002 wdata=0x0000ABCD → be=1100, bus_wdata=0xABCDABCD. LH at same addr with rdata=0x7FFF0000 → rd_data=0x00007FFF.
- LW addr=0x4001 → misalign=1 same cycle, stall=0, bus_req never asserted. LH addr=0x4001 also misaligned; LB addr=0x4001 is not.
- LW with gnt withheld 16 cycles → done=1, err=1, rd_data=0, bus_req low. A late rvalid afterwards changes nothing.
- rstn low during RSP → bus_req, stall, done all 0 immediately, state IDLE. A fresh SW after release completes normally.
